// File: rtl/conn_table_responder_if.sv
// conn_table_responder_if
//   Request/response bundle between the packet parser (master) and the
//   connection-table responder (slave).
//   tuple_data_i  [127:0] 5-tuple request, key in bits [103:0]
//   tuple_valid_i         request level, held with stable data until answered
//   conn_data_o   [15:0]  bit 15 = table full, low bits = slot id
//   conn_valid_o          single-cycle response pulse
interface conn_table_responder_if;
    logic [127:0] tuple_data_i;
    logic         tuple_valid_i;
    logic [15:0]  conn_data_o;
    logic         conn_valid_o;

    modport master (
        output tuple_data_i,
        output tuple_valid_i,
        input  conn_data_o,
        input  conn_valid_o
    );

    modport slave (
        input  tuple_data_i,
        input  tuple_valid_i,
        output conn_data_o,
        output conn_valid_o
    );
endinterface

// File: rtl/conn_table_responder.sv
// conn_table_responder
//   Connection table for the NAT datapath. A 5-tuple key is XOR-folded into
//   a HASH_LEN-bit index and a register table of 2^HASH_LEN entries is
//   linear-probed one slot per cycle. An existing connection returns its
//   slot; a new one is written into the first free slot; a full table
//   returns 16'h8000 without writing.
//
//   Ports:
//     clk      rising-edge clock
//     reset    synchronous, active-low reset
//     conn_if  slave side of conn_table_responder_if (request / response)
//   Optional (macro CONN_STATS_EN):
//     hit_cnt_o, insert_cnt_o, full_cnt_o  32-bit wrapping response counters
//
//   Parameter HASH_LEN: index width, 1..15; table depth 2^HASH_LEN.
module conn_table_responder #(
    parameter int HASH_LEN = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    conn_table_responder_if.slave  conn_if
`ifdef CONN_STATS_EN
    ,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            insert_cnt_o,
    output logic [31:0]            full_cnt_o
`endif
);

    localparam int KEY_W  = 104;
    localparam int DEPTH  = 1 << HASH_LEN;
    localparam int NCHUNK = (KEY_W + HASH_LEN - 1) / HASH_LEN;

    localparam logic [HASH_LEN-1:0] IDX_ONE    = HASH_LEN'(1);
    localparam logic [HASH_LEN:0]   CNT_ONE    = (HASH_LEN + 1)'(1);
    localparam logic [HASH_LEN:0]   PROBE_LAST = (HASH_LEN + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // XOR-fold of the key into HASH_LEN-bit chunks from bit 0; shifting past
    // the top of the key zero-extends the last partial chunk.
    function automatic logic [HASH_LEN-1:0] hash_fold(input logic [KEY_W-1:0] key);
        logic [HASH_LEN-1:0] acc;
        acc = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            acc = acc ^ HASH_LEN'(key >> (c * HASH_LEN));
        end
        return acc;
    endfunction

    state_t              state_r;
    logic [KEY_W-1:0]    key_r;
    logic [HASH_LEN-1:0] idx_r;
    logic [HASH_LEN:0]   probe_cnt_r;
    logic [15:0]         conn_data_r;
    logic                conn_valid_r;
    logic [DEPTH-1:0]    valid_r;
    logic [KEY_W-1:0]    key_tbl_r [DEPTH];

    logic [KEY_W-1:0]    key_in_s;
    logic                entry_valid_s;
    logic                entry_hit_s;
    logic                unused_tag_s;

`ifdef CONN_STATS_EN
    logic [31:0]         hit_cnt_r;
    logic [31:0]         insert_cnt_r;
    logic [31:0]         full_cnt_r;
`endif

    assign key_in_s      = conn_if.tuple_data_i[KEY_W-1:0];
    // Upper tuple bits carry no key information.
    assign unused_tag_s  = ^conn_if.tuple_data_i[127:KEY_W];

    // Combinational read of the slot currently being probed.
    assign entry_valid_s = valid_r[idx_r];
    assign entry_hit_s   = entry_valid_s && (key_tbl_r[idx_r] == key_r);

    // Request FSM, table write port and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            key_r        <= '0;
            idx_r        <= '0;
            probe_cnt_r  <= '0;
            conn_data_r  <= 16'h0000;
            conn_valid_r <= 1'b0;
            valid_r      <= '0;
`ifdef CONN_STATS_EN
            hit_cnt_r    <= 32'd0;
            insert_cnt_r <= 32'd0;
            full_cnt_r   <= 32'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    conn_valid_r <= 1'b0;
                    if (conn_if.tuple_valid_i) begin
                        key_r       <= key_in_s;
                        idx_r       <= hash_fold(key_in_s);
                        probe_cnt_r <= '0;
                        state_r     <= ST_PROBE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_PROBE: begin
                    if (entry_hit_s) begin
                        conn_data_r  <= 16'(idx_r);
                        conn_valid_r <= 1'b1;
                        state_r      <= ST_DONE;
`ifdef CONN_STATS_EN
                        hit_cnt_r    <= hit_cnt_r + 32'd1;
`endif
                    end else if (!entry_valid_s) begin
                        key_tbl_r[idx_r] <= key_r;
                        valid_r[idx_r]   <= 1'b1;
                        conn_data_r      <= 16'(idx_r);
                        conn_valid_r     <= 1'b1;
                        state_r          <= ST_DONE;
`ifdef CONN_STATS_EN
                        insert_cnt_r     <= insert_cnt_r + 32'd1;
`endif
                    end else if (probe_cnt_r == PROBE_LAST) begin
                        // Every slot visited once with no match and no room.
                        conn_data_r  <= 16'h8000;
                        conn_valid_r <= 1'b1;
                        state_r      <= ST_DONE;
`ifdef CONN_STATS_EN
                        full_cnt_r   <= full_cnt_r + 32'd1;
`endif
                    end else begin
                        // idx is HASH_LEN bits, so the increment wraps the table.
                        idx_r        <= idx_r + IDX_ONE;
                        probe_cnt_r  <= probe_cnt_r + CNT_ONE;
                        conn_valid_r <= 1'b0;
                        state_r      <= ST_PROBE;
                    end
                end
                ST_DONE: begin
                    // Wait for the requester to drop its level so a held
                    // request is answered only once.
                    conn_valid_r <= 1'b0;
                    if (!conn_if.tuple_valid_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    conn_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign conn_if.conn_data_o  = conn_data_r;
    assign conn_if.conn_valid_o = conn_valid_r;

`ifdef CONN_STATS_EN
    assign hit_cnt_o    = hit_cnt_r;
    assign insert_cnt_o = insert_cnt_r;
    assign full_cnt_o   = full_cnt_r;
`endif

endmodule

// File: doc/conn_table_responder.md
Name: conn_table_responder

Overview:
Connection-table responder for the NAT datapath. It sits on the tuple/conn side of the packet parser.
- Accepts a 5-tuple request, hashes it, and linear-probes a register-based table.
- Returns the slot index of the existing connection, or inserts the tuple into the first free slot and returns that index.
- The parser stalls its AXI-Stream until conn_valid_o arrives, then writes the returned id into the packet's port field.

Parameters:
HASH_LEN, 6, index width in bits; table depth is 2^HASH_LEN; legal range 1..15.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
tuple_data_i  input  128  {24'h0, src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], protocol[7:0]}; key = bits [103:0], bits [127:104] ignored
tuple_valid_i  input  1  request; level held high with stable data until requester sees conn_valid_o
conn_data_o  output  16  bit 15 = full flag; bits [HASH_LEN-1:0] = slot id; other bits 0
conn_valid_o  output  1  single-cycle response pulse

Behaviour:
- Reset (reset==0 at clk edge): conn_valid_o=0, conn_data_o=0, all slot valid bits cleared, FSM->IDLE. This applies from any state; an in-flight request is dropped with no response.
- Storage: 2^HASH_LEN entries, each {valid, key[103:0]}. Entries are read combinationally at probe index and written on insert.
- Hash: XOR-fold of key[103:0] into HASH_LEN-bit chunks starting at bit 0. The last partial chunk is zero-extended.
- FSM:
  - IDLE: on tuple_valid_i=1, latch key, idx<=hash(key), probe_cnt<=0, ->PROBE.
  - PROBE, one slot per cycle:
    - entry valid and key match: conn_data_o<={0,idx}, conn_valid_o<=1, ->DONE.
    - entry invalid: write key and set valid at idx, conn_data_o<={0,idx}, conn_valid_o<=1, ->DONE.
    - otherwise: idx<=idx+1 mod 2^HASH_LEN (wraps); probe_cnt<=probe_cnt+1.
    - probe_cnt==2^HASH_LEN-1 with no hit and no free slot: conn_data_o<=16'h8000, conn_valid_o<=1, no write, ->DONE.
  - DONE: conn_valid_o<=0. Stay until tuple_valid_i==0, then ->IDLE. This guarantees a held request is never serviced twice.
- Latency: request sampled at edge E; probe k is decided at edge E+1+k. conn_valid_o is high during the cycle after that edge.
  - Best case: response 2 cycles after tuple_valid_i rises.
  - Worst case: 2^HASH_LEN+1 cycles.
- conn_data_o holds its last value between responses.
- probe_cnt is HASH_LEN+1 bits wide. idx arithmetic is HASH_LEN bits, so wrap is natural.
- tuple_valid_i dropping while in PROBE: the request completes anyway. The resulting pulse is harmless because DONE exits immediately.
- No deletion or aging; entries persist until reset.

Optional Feature:
Macro CONN_STATS_EN.
- Defined: adds three outputs, hit_cnt_o[31:0], insert_cnt_o[31:0] and full_cnt_o[31:0].
  - Each increments by 1 on the edge its response type is issued.
  - Each clears on reset and wraps at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- HASH_LEN=6, after reset, tuple_data_i=128'h06 held high -> conn_valid_o pulses 1 cycle exactly 2 cycles after request; conn_data_o=16'h0006; slot 6 valid.
- Repeat 128'h06 after tuple_valid_i low for one cycle -> hit, conn_data_o=16'h0006, no new insert (insert_cnt_o=1, hit_cnt_o=1 if CONN_STATS_EN).
- Collision: 128'h1046 (hash 6) -> probe 6 mismatch, 7 free -> conn_data_o=16'h0007 after 3 cycles.
- Wrap: HASH_LEN=2, fill slots 3 and 0 via tuples hashing to 3 (128'h3, 128'h30) -> second gets 16'h0000. Then 128'hC0, hashing to 3 -> probes 3,0 and gets 16'h0001.
- Full: HASH_LEN=2, insert 4 distinct tuples, then a 5th new tuple -> conn_data_o=16'h8000 after 5 cycles, table unchanged; an existing tuple still hits.
- Held request: keep tuple_valid_i high 10 cycles after response -> exactly one conn_valid_o pulse. Then assert reset low mid-PROBE -> no pulse, all slots invalid, next 128'h06 inserts at 16'h0006.
